// File: rtl/ca_pkg.sv
// ca_pkg: rule-signal codes, updater FSM states and the per-cell code application function.
// Shared by the per-cell signal generation logic and the row updater.
package ca_pkg;
  localparam logic [1:0] SIG_HOLD = 2'b00;
  localparam logic [1:0] SIG_CLR  = 2'b01;
  localparam logic [1:0] SIG_SET  = 2'b10;
  localparam logic [1:0] SIG_BAD  = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_COMMIT} state_t;
  function automatic logic apply_sig(input logic old_bit, input logic [1:0] code);
    return code == SIG_CLR ? 1'b0 : code == SIG_SET ? 1'b1 : old_bit;
  endfunction
endpackage

// File: rtl/ca_row_updater.sv
// ca_row_updater: applies serially delivered per-cell rule codes to a shadow row and commits it atomically.
// Ports: clk/rst (async active-high); load/load_data seed the row in IDLE; start begins a generation;
// abort cancels it; sig_valid/signal/sig_ready is the per-cell code handshake for cell cur_idx;
// row_state is the committed row; busy, done (one-cycle pulse), gen_count and sticky err report status.
module ca_row_updater
  import ca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GEN_W = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             abort,
  input  logic             sig_valid,
  input  logic [1:0]       signal,
  output logic             sig_ready,
  output logic [IDX_W-1:0] cur_idx,
  output logic [WIDTH-1:0] row_state,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count,
  output logic             err
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] row_q, row_d, shadow_q, shadow_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             done_q, done_d, err_q, err_d, last;
  assign last = idx_q == IDX_W'(WIDTH - 1);
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    gen_d    = gen_q;
    err_d    = err_q;
    done_d   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (load) begin
        row_d = load_data;
        err_d = 1'b0;
      end else if (start) begin
        shadow_d = row_q;
        idx_d    = '0;
        state_d  = ST_APPLY;
      end
    end else if (abort) begin
      // abort wins over a same-cycle transfer or commit
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (state_q == ST_APPLY) begin
      if (sig_valid) begin
        shadow_d[idx_q] = apply_sig(shadow_q[idx_q], signal);
        err_d   = err_q | (signal == SIG_BAD);
        idx_d   = last ? '0 : idx_q + 1'b1;
        state_d = last ? ST_COMMIT : ST_APPLY;
      end
    end else begin
      row_d   = shadow_q;
      gen_d   = gen_q + 1'b1;
      done_d  = 1'b1;
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      shadow_q <= '0;
      idx_q    <= '0;
      gen_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      gen_q    <= gen_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  assign sig_ready = state_q == ST_APPLY;
  assign busy      = state_q != ST_IDLE;
  assign cur_idx   = idx_q;
  assign row_state = row_q;
  assign gen_count = gen_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_ca_row_updater.sv
// tb_ca_row_updater: directed scenarios for ca_row_updater with WIDTH=8, GEN_W=4.
module tb_ca_row_updater;
  logic       clk = 0, rst = 0, load = 0, start = 0, abort = 0, sig_valid = 0;
  logic [7:0] load_data = 0;
  logic [1:0] signal = 0;
  logic       sig_ready, busy, done, err;
  logic [2:0] cur_idx;
  logic [7:0] row_state;
  logic [3:0] gen_count;
  int n_cmp = 0, n_bad = 0;

  ca_row_updater #(.WIDTH(8), .GEN_W(4)) dut (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data), .start(start), .abort(abort),
    .sig_valid(sig_valid), .signal(signal), .sig_ready(sig_ready), .cur_idx(cur_idx),
    .row_state(row_state), .busy(busy), .done(done), .gen_count(gen_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    #2;
    rst = 0;
    step();
  endtask

  task automatic load_row(input logic [7:0] d);
    load = 1;
    load_data = d;
    step();
    load = 0;
  endtask

  task automatic start_gen();
    start = 1;
    step();
    start = 0;
  endtask

  // Delivers codes for cells 0..7 (cell i = codes[2i+1:2i]); tallies index and row-stability deviations.
  task automatic apply_row(input logic [15:0] codes, input bit toggle, output int idx_err, output int row_chg);
    logic [7:0] row0;
    logic [15:0] c;
    row0 = row_state;
    c = codes;
    idx_err = 0;
    row_chg = 0;
    for (int i = 0; i < 8; i++) begin
      if (toggle) begin
        sig_valid = 0;
        step();
        if (cur_idx !== 3'(i)) idx_err++;
        if (row_state !== row0) row_chg++;
      end
      if (cur_idx !== 3'(i) || sig_ready !== 1'b1) idx_err++;
      if (row_state !== row0) row_chg++;
      sig_valid = 1;
      signal = c[2*i +: 2];
      step();
    end
    sig_valid = 0;
  endtask

  task automatic test_reset();
    int ie, rc;
    do_reset();
    n_cmp++;
    if (busy !== 0 || done !== 0 || sig_ready !== 0 || row_state !== 0 || gen_count !== 0 || err !== 0 || cur_idx !== 0) begin
      n_bad++;
      $display("FAIL reset_initial: busy=%b done=%b rdy=%b row=%h gen=%0d err=%b idx=%0d want all 0", busy, done, sig_ready, row_state, gen_count, err, cur_idx);
    end
    load_row(8'hFF);
    start_gen();
    sig_valid = 1;
    signal = 2'b11;
    step();
    signal = 2'b01;
    step();
    step();
    sig_valid = 0;
    rst = 1;
    #1;
    n_cmp++;
    if (busy !== 0 || done !== 0 || sig_ready !== 0 || row_state !== 0 || gen_count !== 0 || err !== 0 || cur_idx !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_apply: busy=%b rdy=%b row=%h gen=%0d err=%b idx=%0d want all 0", busy, sig_ready, row_state, gen_count, err, cur_idx);
    end
    #1;
    rst = 0;
    step();
    n_cmp++;
    if (busy !== 0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
    ie = 0;
    rc = 0;
  endtask

  // cells 0..7 = 10,01,00,10,01,00,00,10 on 8'hA5 gives 8'hAD
  task automatic test_basic(input bit toggle, input logic [3:0] gen_exp, input string nm);
    int ie, rc;
    load_row(8'hA5);
    start_gen();
    apply_row(16'h8186, toggle, ie, rc);
    n_cmp++;
    if (ie != 0 || rc != 0) begin
      n_bad++;
      $display("FAIL %s_apply: idx_err=%0d row_changes=%0d want 0/0", nm, ie, rc);
    end
    n_cmp++;
    if (busy !== 1 || done !== 0 || row_state !== 8'hA5) begin
      n_bad++;
      $display("FAIL %s_commit_cycle: busy=%b done=%b row=%h want 1/0/a5", nm, busy, done, row_state);
    end
    step();
    n_cmp++;
    if (done !== 1 || row_state !== 8'hAD || gen_count !== gen_exp || busy !== 0 || cur_idx !== 0) begin
      n_bad++;
      $display("FAIL %s_done: done=%b row=%h gen=%0d busy=%b idx=%0d want 1/ad/%0d/0/0", nm, done, row_state, gen_count, busy, cur_idx, gen_exp);
    end
    step();
    n_cmp++;
    if (done !== 0 || row_state !== 8'hAD) begin
      n_bad++;
      $display("FAIL %s_done_once: done=%b row=%h want 0/ad", nm, done, row_state);
    end
  endtask

  task automatic test_abort();
    int ie, rc;
    load_row(8'h0F);
    start_gen();
    sig_valid = 1;
    signal = 2'b10;
    repeat (5) step();
    abort = 1;
    step();
    abort = 0;
    sig_valid = 0;
    n_cmp++;
    if (busy !== 0 || cur_idx !== 0 || row_state !== 8'h0F || gen_count !== 4'd2 || done !== 0) begin
      n_bad++;
      $display("FAIL abort_state: busy=%b idx=%0d row=%h gen=%0d done=%b want 0/0/0f/2/0", busy, cur_idx, row_state, gen_count, done);
    end
    step();
    n_cmp++;
    if (done !== 0 || busy !== 0) begin
      n_bad++;
      $display("FAIL abort_no_done: done=%b busy=%b want 0/0", done, busy);
    end
    start_gen();
    n_cmp++;
    if (cur_idx !== 0 || busy !== 1 || sig_ready !== 1) begin
      n_bad++;
      $display("FAIL abort_restart: idx=%0d busy=%b rdy=%b want 0/1/1", cur_idx, busy, sig_ready);
    end
    apply_row(16'h0000, 0, ie, rc);
    step();
    n_cmp++;
    if (done !== 1 || row_state !== 8'h0F || gen_count !== 4'd3 || ie != 0) begin
      n_bad++;
      $display("FAIL abort_regen: done=%b row=%h gen=%0d idx_err=%0d want 1/0f/3/0", done, row_state, gen_count, ie);
    end
  endtask

  // code 11 on cell 2 and 10 on cell 0 over 8'h00 gives 8'h01
  task automatic test_err();
    int ie, rc;
    load_row(8'h00);
    start_gen();
    apply_row(16'h0032, 0, ie, rc);
    step();
    n_cmp++;
    if (done !== 1 || row_state !== 8'h01 || err !== 1 || gen_count !== 4'd4) begin
      n_bad++;
      $display("FAIL err_set: done=%b row=%h err=%b gen=%0d want 1/01/1/4", done, row_state, err, gen_count);
    end
    start_gen();
    apply_row(16'h0000, 0, ie, rc);
    step();
    n_cmp++;
    if (err !== 1 || row_state !== 8'h01 || gen_count !== 4'd5) begin
      n_bad++;
      $display("FAIL err_sticky: err=%b row=%h gen=%0d want 1/01/5", err, row_state, gen_count);
    end
    step();
    load_row(8'h00);
    n_cmp++;
    if (err !== 0 || row_state !== 8'h00) begin
      n_bad++;
      $display("FAIL err_clear: err=%b row=%h want 0/00", err, row_state);
    end
  endtask

  task automatic test_back_to_back();
    int ie, rc, bad_done, bad_gen, bad_idx;
    logic [3:0] g_exp;
    do_reset();
    load_row(8'h81);
    bad_done = 0;
    bad_gen = 0;
    bad_idx = 0;
    g_exp = 0;
    start_gen();
    for (int g = 0; g < 16; g++) begin
      apply_row(16'h0000, 0, ie, rc);
      bad_idx += ie + rc;
      step();
      g_exp = g_exp + 4'd1;
      if (done !== 1) bad_done++;
      if (gen_count !== g_exp) bad_gen++;
      if (g < 15) start_gen();
    end
    n_cmp++;
    if (bad_done != 0 || bad_gen != 0 || bad_idx != 0) begin
      n_bad++;
      $display("FAIL b2b_sequence: done_misses=%0d gen_misses=%0d idx_err=%0d want 0/0/0", bad_done, bad_gen, bad_idx);
    end
    n_cmp++;
    if (gen_count !== 4'd0 || row_state !== 8'h81) begin
      n_bad++;
      $display("FAIL b2b_wrap: gen=%0d row=%h want 0/81", gen_count, row_state);
    end
    step();
    load = 1;
    start = 1;
    load_data = 8'h3C;
    step();
    load = 0;
    start = 0;
    n_cmp++;
    if (row_state !== 8'h3C || busy !== 0 || sig_ready !== 0) begin
      n_bad++;
      $display("FAIL load_start: row=%h busy=%b rdy=%b want 3c/0/0", row_state, busy, sig_ready);
    end
    step();
    n_cmp++;
    if (busy !== 0 || done !== 0 || gen_count !== 4'd0) begin
      n_bad++;
      $display("FAIL load_start_idle: busy=%b done=%b gen=%0d want 0/0/0", busy, done, gen_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic(0, 4'd1, "basic");
    test_basic(1, 4'd2, "stall");
    test_abort();
    test_err();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1);
  end
endmodule
